// File: rtl/opb_register_bank_simulink2ppc.sv
// opb_register_bank_simulink2ppc: OPB slave exposing C_N_CH user registers and a CTRL word with snapshot/freeze.
// Optional macro OPB_REGBANK_UPDCNT_EN adds a 16-bit update counter per channel at words C_N_CH+1..2*C_N_CH.
module opb_register_bank_simulink2ppc #(
   parameter int                      C_OPB_AWIDTH = 32,
   parameter int                      C_OPB_DWIDTH = 32,
   parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h01008B00,
   parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h01008BFF,
   parameter int                      C_N_CH       = 4,
   parameter                          C_FAMILY     = "virtex5"
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
   output logic                    Sl_xferAck,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   input  logic [32*C_N_CH-1:0]    user_data_in,
   input  logic [C_N_CH-1:0]       user_valid
);
   localparam int WW = C_OPB_AWIDTH - 2;
   typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT} state_t;
   state_t                  state_q;
   logic [WW-1:0]           w_q;
   logic                    rnw_q, be3_q, freeze_q, ack_q, hit, wr_ctrl, snap_now;
   logic [1:0]              d_q;
   logic [C_OPB_AWIDTH-1:0] off;
   logic [C_OPB_DWIDTH-1:0] rdata, dbus_q;
   logic [C_N_CH-1:0][31:0] live_q, live_d, snap_q;
`ifdef OPB_REGBANK_UPDCNT_EN
   logic [C_N_CH-1:0][15:0] cnt_q, cnt_d, csnap_q;
`endif
   logic                    unused;

   assign unused     = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:C_OPB_DWIDTH-3], off[1:0]};
   assign off        = OPB_ABus - C_BASEADDR;
   assign hit        = OPB_select && OPB_ABus >= C_BASEADDR && OPB_ABus <= C_HIGHADDR;
   // d_q[1] is the snapshot pulse bit, d_q[0] the freeze bit; rising freeze also snapshots
   assign wr_ctrl    = state_q == S_XFER && !rnw_q && be3_q && w_q == WW'(C_N_CH);
   assign snap_now   = wr_ctrl && (d_q[1] || (d_q[0] && !freeze_q));
   assign Sl_DBus    = dbus_q;
   assign Sl_xferAck = ack_q;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   // next live (and counter) values: a strobed channel takes this cycle's user data
   always_comb begin
      live_d = live_q;
`ifdef OPB_REGBANK_UPDCNT_EN
      cnt_d = cnt_q;
`endif
      for (int i = 0; i < C_N_CH; i++) begin
         if (user_valid[i]) begin
            live_d[i] = user_data_in[32*i +: 32];
`ifdef OPB_REGBANK_UPDCNT_EN
            cnt_d[i] = cnt_q[i] + 16'd1;
`endif
         end
      end
   end

   // read mux over the registered word index; frozen reads come from the snapshot
   always_comb begin
      rdata = '0;
      for (int i = 0; i < C_N_CH; i++) begin
         if (w_q == WW'(i)) rdata = C_OPB_DWIDTH'(freeze_q ? snap_q[i] : live_q[i]);
`ifdef OPB_REGBANK_UPDCNT_EN
         if (w_q == WW'(C_N_CH + 1 + i)) rdata = C_OPB_DWIDTH'({16'b0, freeze_q ? csnap_q[i] : cnt_q[i]});
`endif
      end
      if (w_q == WW'(C_N_CH)) rdata = C_OPB_DWIDTH'({8'(C_N_CH), 23'b0, freeze_q});
   end

   // user-side live registers (and counters)
   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst_n) begin
         live_q <= '0;
`ifdef OPB_REGBANK_UPDCNT_EN
         cnt_q <= '0;
`endif
      end else begin
         live_q <= live_d;
`ifdef OPB_REGBANK_UPDCNT_EN
         cnt_q <= cnt_d;
`endif
      end
   end

   // bus FSM with registered ack/data, CTRL freeze bit and snapshot capture
   always_ff @(posedge OPB_Clk) begin
      if (!OPB_Rst_n) begin
         state_q  <= S_IDLE;
         ack_q    <= 1'b0;
         dbus_q   <= '0;
         w_q      <= '0;
         rnw_q    <= 1'b0;
         be3_q    <= 1'b0;
         d_q      <= '0;
         freeze_q <= 1'b0;
         snap_q   <= '0;
`ifdef OPB_REGBANK_UPDCNT_EN
         csnap_q  <= '0;
`endif
      end else begin
         ack_q  <= 1'b0;
         dbus_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (hit) begin
                  state_q <= S_XFER;
                  w_q     <= off[C_OPB_AWIDTH-1:2];
                  rnw_q   <= OPB_RNW;
                  be3_q   <= OPB_BE[3];
                  d_q     <= OPB_DBus[C_OPB_DWIDTH-2 +: 2];
               end
            end
            S_XFER: begin
               state_q <= S_WAIT;
               ack_q   <= 1'b1;
               dbus_q  <= rnw_q ? rdata : '0;
               if (wr_ctrl) freeze_q <= d_q[0];
            end
            default: if (!OPB_select) state_q <= S_IDLE;
         endcase
         if (snap_now) begin
            snap_q  <= live_d;
`ifdef OPB_REGBANK_UPDCNT_EN
            csnap_q <= cnt_d;
`endif
         end
      end
   end
endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// tb_opb_register_bank_simulink2ppc: scoreboard bench with a behavioural register-bank model.
module tb_opb_register_bank_simulink2ppc;
   localparam int N = 4;
   localparam logic [31:0] BASE = 32'h01008B00;
   localparam logic [31:0] HIGH = 32'h01008BFF;
`ifdef OPB_REGBANK_UPDCNT_EN
   localparam bit UPD = 1'b1;
`else
   localparam bit UPD = 1'b0;
`endif

   typedef struct { logic [31:0] data; int cyc; } exp_t;
   exp_t expq[$];
   exp_t e;
   int checks = 0, failures = 0, cyc = 0;
   bit mon_en = 0;

   logic clk = 0, rst_n, rnw, sel, seq;
   logic [0:31] abus, dbus_w, Sl_DBus;
   logic [0:3] be;
   logic Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
   logic [32*N-1:0] udata;
   logic [N-1:0] uv;

   logic [31:0] live[N], snap[N];
   logic [15:0] cnt[N], csnap[N];
   bit freeze;

   opb_register_bank_simulink2ppc #(
      .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_N_CH(N)
   ) dut (
      .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_w),
      .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(Sl_DBus),
      .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
      .Sl_toutSup(Sl_toutSup), .user_data_in(udata), .user_valid(uv)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         live[i] = 0; snap[i] = 0; cnt[i] = 0; csnap[i] = 0;
      end
      freeze = 0;
   endfunction

   function automatic void apply(input logic [N-1:0] m, input logic [32*N-1:0] ud);
      for (int i = 0; i < N; i++) if (m[i]) begin
         live[i] = ud[32*i +: 32];
         cnt[i] = cnt[i] + 16'd1;
      end
   endfunction

   function automatic logic [31:0] mread(input logic [31:0] a);
      int w = int'((a - BASE) >> 2);
      if (w < N) return freeze ? snap[w] : live[w];
      if (w == N) return {8'(N), 23'b0, freeze};
      if (w <= 2 * N && UPD) return {16'b0, freeze ? csnap[w-N-1] : cnt[w-N-1]};
      return 32'h0;
   endfunction

   function automatic void mwrite(input logic [31:0] a, input logic [31:0] d, input logic [0:3] b);
      int w = int'((a - BASE) >> 2);
      bit s;
      if (w == N && b[3]) begin
         s = d[1] || (d[0] && !freeze);
         freeze = d[0];
         if (s) for (int i = 0; i < N; i++) begin
            snap[i] = live[i]; csnap[i] = cnt[i];
         end
      end
   endfunction

   // one OPB transaction; m/ud are user strobes driven in the transfer cycle
   task automatic bus(input bit r, input logic [31:0] a, input logic [31:0] d, input logic [0:3] b,
                      input int hold, input logic [N-1:0] m, input logic [32*N-1:0] ud);
      bit h;
      exp_t t;
      @(negedge clk);
      sel = 1; rnw = r; abus = a; dbus_w = d; be = b;
      h = a >= BASE && a <= HIGH;
      t.data = (h && r) ? mread(a) : 32'h0;
      t.cyc = cyc + 2;
      if (h) expq.push_back(t);
      @(negedge clk);
      uv = m; udata = ud; apply(m, ud);
      if (h && !r) mwrite(a, d, b);
      @(negedge clk);
      uv = '0;
      repeat (hold - 2) @(negedge clk);
      sel = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic upd(input logic [N-1:0] m, input logic [32*N-1:0] ud);
      @(negedge clk);
      uv = m; udata = ud; apply(m, ud);
      @(negedge clk);
      uv = '0;
   endtask

   // monitor: every ack pops the scoreboard; idle cycles must show zero data
   always @(negedge clk) if (mon_en) begin
      checks++;
      if (Sl_errAck !== 1'b0 || Sl_retry !== 1'b0 || Sl_toutSup !== 1'b0) begin
         failures++;
         $display("FAIL tied_outputs errAck=%b retry=%b toutSup=%b required 0", Sl_errAck, Sl_retry, Sl_toutSup);
      end
      if (expq.size() > 0 && expq[0].cyc < cyc) begin
         checks++; failures++;
         $display("FAIL missing_ack cyc=%0d required ack at cyc=%0d", cyc, expq[0].cyc);
         void'(expq.pop_front());
      end
      if (Sl_xferAck === 1'b1) begin
         checks++;
         if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack cyc=%0d dbus=%h required no ack", cyc, Sl_DBus);
         end else begin
            e = expq.pop_front();
            if (e.cyc != cyc) begin
               failures++;
               $display("FAIL ack_latency got cyc=%0d required cyc=%0d", cyc, e.cyc);
            end
            checks++;
            if (Sl_DBus !== e.data) begin
               failures++;
               $display("FAIL ack_data got %h required %h", Sl_DBus, e.data);
            end
         end
      end else if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0) begin
         failures++;
         $display("FAIL idle_outputs ack=%b dbus=%h required ack=0 dbus=0", Sl_xferAck, Sl_DBus);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      logic [0:3] b;
      logic [N-1:0] m;
      logic [32*N-1:0] ud;
      int p;
      rst_n = 0; sel = 0; rnw = 1; abus = 0; dbus_w = 0; be = 4'hF; seq = 0;
      uv = '1; udata = {N{32'hFFFFFFFF}};
      model_reset();
      @(posedge clk); #1 mon_en = 1;
      repeat (3) @(negedge clk);
      rst_n = 1; uv = '0;
      bus(1, BASE, 0, 4'hF, 3, '0, '0);
      // counter wrap: 65537 strobes on channel 3
      @(negedge clk);
      udata = '0; udata[96 +: 32] = 32'h0000_3333; uv = 4'b1000;
      repeat (65537) @(negedge clk);
      uv = '0;
      live[3] = 32'h0000_3333;
      cnt[3] = 16'(cnt[3] + 65537);
      bus(1, BASE + 32'(4 * (N + 4)), 0, 4'hF, 3, '0, '0);
      // live read
      ud = '0; ud[64 +: 32] = 32'hDEADBEEF;
      upd(4'b0100, ud);
      bus(1, BASE + 8, 0, 4'hF, 3, '0, '0);
      // freeze holds the snapshot until released
      ud = '0; ud[32 +: 32] = 32'h11;
      upd(4'b0010, ud);
      bus(0, BASE + 4 * N, 32'h1, 4'hF, 3, '0, '0);
      ud[32 +: 32] = 32'h22;
      upd(4'b0010, ud);
      bus(1, BASE + 4, 0, 4'hF, 3, '0, '0);
      bus(0, BASE + 4 * N, 32'h0, 4'hF, 3, '0, '0);
      bus(1, BASE + 4, 0, 4'hF, 3, '0, '0);
      // snapshot coincident with a user strobe while frozen
      bus(0, BASE + 4 * N, 32'h1, 4'hF, 3, '0, '0);
      ud = '0; ud[0 +: 32] = 32'hA5A5A5A5;
      bus(0, BASE + 4 * N, 32'h3, 4'hF, 3, 4'b0001, ud);
      bus(1, BASE, 0, 4'hF, 3, '0, '0);
      // bus rules
      bus(1, BASE + 8, 0, 4'hF, 5, '0, '0);
      bus(1, HIGH + 4, 0, 4'hF, 4, '0, '0);
      bus(1, BASE - 4, 0, 4'hF, 4, '0, '0);
      bus(0, BASE + 4 * N, 32'h0, 4'b1110, 3, '0, '0);
      bus(1, BASE + 4 * N, 0, 4'hF, 3, '0, '0);
      bus(0, BASE + 4 * N, 32'h0, 4'hF, 3, '0, '0);
      bus(1, BASE + 4 * N, 0, 4'b0000, 3, '0, '0);
      bus(1, HIGH - 3, 0, 4'hF, 3, '0, '0);
      // reset during a transfer aborts it
      @(negedge clk);
      sel = 1; rnw = 1; abus = BASE + 4 * N;
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1; sel = 0; model_reset();
      repeat (2) @(negedge clk);
      bus(1, BASE + 8, 0, 4'hF, 3, '0, '0);
      bus(1, BASE + 4 * N, 0, 4'hF, 3, '0, '0);
      // randomized traffic
      for (int k = 0; k < 300; k++) begin
         p = $urandom_range(0, 2 * N + 5);
         a = (p <= 2 * N + 2) ? BASE + 32'(4 * p) + 32'($urandom_range(0, 3)) :
             (p == 2 * N + 3) ? BASE - 4 : (p == 2 * N + 4) ? HIGH + 1 : HIGH - 3;
         d = $urandom;
         b = 4'($urandom);
         m = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
         for (int i = 0; i < N; i++) ud[32*i +: 32] = $urandom;
         bus(1'($urandom), a, d, b, $urandom_range(2, 6), m, ud);
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < N; i++) ud[32*i +: 32] = $urandom;
            upd(N'($urandom), ud);
         end
      end
      repeat (5) @(negedge clk);
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required 0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
